// File: rtl/correlator_pkg.sv
// Shared types and constants for the correlator sample scheduler.
package correlator_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAMPLING = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned clamp_exp(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/jitter_lfsr.sv
// 16-bit Galois LFSR supplying the pseudo-random sample jitter.
module jitter_lfsr
  import correlator_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_adv,
  output logic [15:0] o_state
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_adv) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign o_state = lfsr_q;

endmodule

// File: rtl/correlator_sample_sched.sv
// Sample strobe generator: jittered period, power-of-two windows, and
// result hand-off to the USB readout side.
module correlator_sample_sched
  import correlator_pkg::*;
#(
  parameter int unsigned MAX_WINDOW_LENGTH_EXP = 16,
  parameter int unsigned MAX_SAMPLE_PERIOD_EXP = 15,
  parameter int unsigned MAX_SAMPLE_JITTER_EXP = 8,
  parameter logic [15:0] LFSR_SEED             = 16'hACE1,
  localparam int unsigned WEXP_W = $clog2(MAX_WINDOW_LENGTH_EXP + 1),
  localparam int unsigned JEXP_W = $clog2(MAX_SAMPLE_JITTER_EXP + 1),
  localparam int unsigned CNT_W  = MAX_SAMPLE_PERIOD_EXP + 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_cg,
  input  logic                             i_cfgEnable,
  input  logic                             i_cfgOneShot,
  input  logic [WEXP_W-1:0]                i_cfgWindowLengthExp,
  input  logic [MAX_SAMPLE_PERIOD_EXP-1:0] i_cfgSamplePeriod,
  input  logic [JEXP_W-1:0]                i_cfgSampleJitterExp,
  input  logic                             i_ackWindow,
  output logic                             o_sampleStrobe,
  output logic                             o_windowStart,
  output logic                             o_windowEnd,
  output logic [MAX_WINDOW_LENGTH_EXP-1:0] o_windowIdx,
  output logic                             o_windowAbort,
  output logic                             o_resultValid,
  output logic                             o_busy
);

  localparam int unsigned MWL = MAX_WINDOW_LENGTH_EXP;
  localparam logic [MWL-1:0] IDX_ONES = '1;

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [MWL-1:0]                     idx_q, idx_d;
  logic [WEXP_W-1:0]                  w_q, w_d;
  logic [MAX_SAMPLE_PERIOD_EXP-1:0]   p_q, p_d;
  logic [JEXP_W-1:0]                  j_q, j_d;
  logic                               abort_q, abort_d;

  logic [15:0]      lfsr;
  logic [15:0]      jmask;
  logic [MWL-1:0]   last_idx;
  logic [CNT_W-1:0] p_eff, interval;
  logic             strobe_raw, start_win;

  jitter_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_adv   (i_cg & strobe_raw),
    .o_state (lfsr)
  );

  always_comb begin
    strobe_raw = (state_q == SAMPLING) && (cnt_q == '0);
    last_idx   = ~(IDX_ONES << w_q);
    jmask      = ~(16'hFFFF << j_q);
    p_eff      = (p_q == '0) ? CNT_W'(1) : CNT_W'(p_q);
    interval   = p_eff + CNT_W'(lfsr & jmask);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    w_d       = w_q;
    p_d       = p_q;
    j_d       = j_q;
    abort_d   = abort_q;
    start_win = 1'b0;
    if (i_cg) begin
      abort_d = 1'b0;
      case (state_q)
        IDLE: if (i_cfgEnable) start_win = 1'b1;
        SAMPLING: begin
          // A window whose end strobe coincides with enable dropping is complete, not aborted.
          if (strobe_raw && idx_q == last_idx) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = WAIT_ACK;
          end else if (!i_cfgEnable) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
            abort_d = 1'b1;
          end else if (strobe_raw) begin
            cnt_d = interval - CNT_W'(1);
            idx_d = idx_q + MWL'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          if (i_ackWindow) begin
            if (i_cfgEnable && !i_cfgOneShot) start_win = 1'b1;
            else                              state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (start_win) begin
        state_d = SAMPLING;
        cnt_d   = '0;
        idx_d   = '0;
        w_d     = WEXP_W'(clamp_exp(32'(i_cfgWindowLengthExp), MAX_WINDOW_LENGTH_EXP));
        p_d     = i_cfgSamplePeriod;
        j_d     = JEXP_W'(clamp_exp(32'(i_cfgSampleJitterExp), MAX_SAMPLE_JITTER_EXP));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      w_q     <= '0;
      p_q     <= '0;
      j_q     <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      p_q     <= p_d;
      j_q     <= j_d;
      abort_q <= abort_d;
    end
  end

  // Pulses are masked while gated so a frozen cycle never repeats a strobe.
  assign o_sampleStrobe = i_cg & strobe_raw;
  assign o_windowStart  = o_sampleStrobe & (idx_q == '0);
  assign o_windowEnd    = o_sampleStrobe & (idx_q == last_idx);
  assign o_windowIdx    = idx_q;
  assign o_windowAbort  = i_cg & abort_q;
  assign o_resultValid  = (state_q == WAIT_ACK);
  assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_correlator_sample_sched.sv
// Randomized and directed bench for correlator_sample_sched against an
// event-time reference model.
module tb_correlator_sample_sched;

  logic        clk = 1'b0;
  logic        rst, cg, en, os, ack;
  logic [4:0]  cfg_w;
  logic [14:0] cfg_p;
  logic [3:0]  cfg_j;
  logic        strobe, wstart, wend, abort, rvalid, busy;
  logic [15:0] widx;

  correlator_sample_sched #(
    .MAX_WINDOW_LENGTH_EXP (16),
    .MAX_SAMPLE_PERIOD_EXP (15),
    .MAX_SAMPLE_JITTER_EXP (8),
    .LFSR_SEED             (16'hACE1)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_cg                 (cg),
    .i_cfgEnable          (en),
    .i_cfgOneShot         (os),
    .i_cfgWindowLengthExp (cfg_w),
    .i_cfgSamplePeriod    (cfg_p),
    .i_cfgSampleJitterExp (cfg_j),
    .i_ackWindow          (ack),
    .o_sampleStrobe       (strobe),
    .o_windowStart        (wstart),
    .o_windowEnd          (wend),
    .o_windowIdx          (widx),
    .o_windowAbort        (abort),
    .o_resultValid        (rvalid),
    .o_busy               (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [21:0] obs, exp_v;
  assign obs = {strobe, wstart, wend, abort, rvalid, busy, widx};

  // Reference model: mode 0=idle 1=sampling 2=waiting; strobes scheduled in
  // absolute active-cycle time.
  int unsigned m_mode, m_t, m_next, m_idx, m_w, m_p, m_j, m_lfsr;
  bit          m_abort;

  function automatic int unsigned ref_lfsr_next(input int unsigned l);
    int unsigned taps;
    taps = (1 << 15) | (1 << 13) | (1 << 12) | (1 << 10);
    return (l % 2 == 1) ? ((l / 2) ^ taps) : (l / 2);
  endfunction

  function automatic bit m_strobe_now();
    return cg && m_mode == 1 && m_t == m_next;
  endfunction

  task automatic m_start();
    m_mode = 1;
    m_next = m_t + 1;
    m_idx  = 0;
    m_w    = (cfg_w > 16) ? 16 : cfg_w;
    m_p    = cfg_p;
    m_j    = (cfg_j > 8) ? 8 : cfg_j;
  endtask

  task automatic eval();
    bit s;
    #1;
    s = m_strobe_now();
    exp_v = {s, s && m_idx == 0, s && m_idx == (1 << m_w) - 1, cg && m_abort,
             m_mode == 2, m_mode != 0, 16'(m_idx)};
  endtask

  task automatic adv();
    bit s, ab;
    int unsigned ival;
    if (rst) begin
      m_mode = 0; m_t = 0; m_next = 0; m_idx = 0; m_abort = 0; m_lfsr = 16'hACE1;
      m_w = 0; m_p = 0; m_j = 0;
    end else if (cg) begin
      s  = m_strobe_now();
      ab = 0;
      case (m_mode)
        0: if (en) m_start();
        1: begin
          if (s) begin
            ival   = ((m_p == 0) ? 1 : m_p) + (m_lfsr & ((1 << m_j) - 1));
            m_lfsr = ref_lfsr_next(m_lfsr);
            if (m_idx == (1 << m_w) - 1) begin m_mode = 2; m_idx = 0; end
            else if (!en) begin ab = 1; m_mode = 0; m_idx = 0; end
            else begin m_next = m_t + ival; m_idx++; end
          end else if (!en) begin
            ab = 1; m_mode = 0; m_idx = 0;
          end
        end
        default: if (ack) begin
          if (en && !os) m_start();
          else m_mode = 0;
        end
      endcase
      m_abort = ab;
      m_t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; cg = 1; en = 0; os = 0; ack = 0;
    adv(); adv();
    rst = 0;
  endtask

  task automatic test_reset();
    cfg_w = 0; cfg_p = 0; cfg_j = 0;
    do_reset();
    eval();
    checks++;
    if (obs !== 22'h0) begin
      failures++; $display("FAIL reset_outputs got=%h want=%h", obs, 22'h0);
    end
  endtask

  task automatic test_basic();
    int st[$];
    int start_c = -1, end_c = -1, rv_c = -1;
    do_reset();
    cfg_w = 2; cfg_p = 3; cfg_j = 0; en = 1;
    for (int c = 0; c < 14; c++) begin
      eval();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL basic_c%0d got=%h want=%h", c, obs, exp_v); end
      if (strobe) st.push_back(c);
      if (wstart && start_c < 0) start_c = c;
      if (wend && end_c < 0) end_c = c;
      if (rvalid && rv_c < 0) rv_c = c;
      adv();
    end
    checks++;
    if (st.size() != 4 || st[0] != 1 || st[1] != 4 || st[2] != 7 || st[3] != 10) begin
      failures++; $display("FAIL basic_strobe_cycles got_n=%0d want=1,4,7,10", st.size());
    end
    checks++;
    if (start_c != 1 || end_c != 10 || rv_c != 11) begin
      failures++; $display("FAIL basic_window_marks got=%0d,%0d,%0d want=1,10,11", start_c, end_c, rv_c);
    end
    en = 0; ack = 1; eval(); adv(); ack = 0;
  endtask

  task automatic test_oneshot();
    int ns = 0, nse = 0;
    do_reset();
    cfg_w = 0; cfg_p = 0; cfg_j = 0; os = 1; en = 1;
    for (int c = 0; c < 6; c++) begin
      eval();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL oneshot_c%0d got=%h want=%h", c, obs, exp_v); end
      if (strobe) ns++;
      if (strobe && wstart && wend) nse++;
      adv();
    end
    checks++;
    if (ns != 1 || nse != 1 || rvalid !== 1'b1) begin
      failures++; $display("FAIL oneshot_single got=%0d/%0d rv=%b want=1/1 rv=1", ns, nse, rvalid);
    end
    ack = 1; eval(); adv(); ack = 0;
    eval();
    checks++;
    if (busy !== 1'b0 || rvalid !== 1'b0) begin
      failures++; $display("FAIL oneshot_idle got busy=%b rv=%b want 0 0", busy, rvalid);
    end
    en = 0; adv(); os = 0;
  endtask

  task automatic test_wait_hold();
    bit reached = 0;
    do_reset();
    cfg_w = 1; cfg_p = 2; cfg_j = 2; en = 1;
    for (int c = 0; c < 200 && !reached; c++) begin
      eval();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL wait_run_c%0d got=%h want=%h", c, obs, exp_v); end
      if (rvalid) reached = 1;
      else adv();
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL wait_timeout got=no_result want=result"); end
    for (int c = 0; c < 20; c++) begin
      adv(); eval();
      checks++;
      if (obs !== exp_v || strobe !== 1'b0) begin
        failures++; $display("FAIL wait_hold_c%0d got=%h want=%h", c, obs, exp_v);
      end
    end
    ack = 1; adv(); ack = 0; eval();
    checks++;
    if (strobe !== 1'b1 || wstart !== 1'b1 || widx !== 16'd0 || obs !== exp_v) begin
      failures++; $display("FAIL wait_resume got=%h want=strobe,start,idx0 (%h)", obs, exp_v);
    end
    en = 0; adv(); adv();
  endtask

  task automatic test_jitter();
    int stamp[$];
    int unsigned l, gap, want;
    do_reset();
    cfg_w = 16; cfg_p = 4; cfg_j = 3; en = 1;
    for (int c = 0; c < 64 * 12 + 20 && stamp.size() < 64; c++) begin
      eval();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL jitter_c%0d got=%h want=%h", c, obs, exp_v); end
      if (strobe) stamp.push_back(c);
      adv();
    end
    checks++;
    if (stamp.size() != 64) begin
      failures++; $display("FAIL jitter_count got=%0d want=64", stamp.size());
    end else begin
      l = 16'hACE1;
      for (int k = 0; k < 63; k++) begin
        gap  = stamp[k + 1] - stamp[k];
        want = 4 + (l & 7);
        l    = ref_lfsr_next(l);
        checks++;
        if (gap < 4 || gap > 11) begin failures++; $display("FAIL jitter_range%0d got=%0d want=4..11", k, gap); end
        checks++;
        if (gap != want) begin failures++; $display("FAIL jitter_gap%0d got=%0d want=%0d", k, gap, want); end
      end
    end
    en = 0; adv(); adv();
  endtask

  task automatic test_abort();
    int n = 0;
    do_reset();
    cfg_w = 4; cfg_p = 2; cfg_j = 1; en = 1;
    for (int c = 0; c < 200 && n < 5; c++) begin
      eval();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL abort_run_c%0d got=%h want=%h", c, obs, exp_v); end
      if (strobe) n++;
      adv();
    end
    en = 0; eval();
    checks++;
    if (widx !== 16'd5 || strobe !== 1'b0 || obs !== exp_v) begin
      failures++; $display("FAIL abort_pre got idx=%0d strobe=%b want idx=5 strobe=0", widx, strobe);
    end
    adv(); eval();
    checks++;
    if (abort !== 1'b1 || wend !== 1'b0 || busy !== 1'b0 || rvalid !== 1'b0 || obs !== exp_v) begin
      failures++; $display("FAIL abort_pulse got=%h want abort=1 end=0 busy=0 rv=0", obs);
    end
    adv(); eval();
    checks++;
    if (abort !== 1'b0 || obs !== exp_v) begin
      failures++; $display("FAIL abort_single got abort=%b want 0", abort);
    end
  endtask

  task automatic test_cg_rst();
    logic [15:0] held;
    do_reset();
    cfg_w = 3; cfg_p = 5; cfg_j = 2; en = 1;
    for (int c = 0; c < 12; c++) begin
      eval(); checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL cg_pre_c%0d got=%h want=%h", c, obs, exp_v); end
      adv();
    end
    cg = 0; held = widx;
    for (int c = 0; c < 7; c++) begin
      eval(); checks++;
      if (obs !== exp_v || strobe !== 1'b0 || widx !== held || busy !== 1'b1) begin
        failures++; $display("FAIL cg_freeze_c%0d got=%h want=%h", c, obs, exp_v);
      end
      adv();
    end
    cg = 1;
    for (int c = 0; c < 20; c++) begin
      eval(); checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL cg_resume_c%0d got=%h want=%h", c, obs, exp_v); end
      adv();
    end
    rst = 1; cg = 0; adv(); rst = 0; cg = 1; eval();
    checks++;
    if (obs !== 22'h0 || obs !== exp_v) begin
      failures++; $display("FAIL rst_mid got=%h want=%h", obs, 22'h0);
    end
    en = 0; adv();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst   = ($urandom % 300) == 0;
      cg    = ($urandom % 8) != 0;
      en    = ($urandom % 20) != 0;
      ack   = ($urandom % 4) == 0;
      os    = ($urandom % 4) == 0;
      cfg_w = 5'($urandom % 4);
      cfg_p = 15'($urandom % 7);
      cfg_j = 4'($urandom % 16);
      eval(); checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL random_c%0d got=%h want=%h", c, obs, exp_v); end
      adv();
    end
    rst = 0; cg = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_oneshot();
    test_wait_hold();
    test_jitter();
    test_abort();
    test_cg_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
